// File: rtl/instr_prefetch_queue_if.sv
// Instruction-fetch bus bundle: memory request/ack side, decode side and redirect.
// The master modport is the prefetch queue itself; slave is the surrounding pipeline/memory.
interface instr_prefetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [3:0]  fifo_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc, fifo_count,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc, fifo_count,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch engine feeding a small FIFO of
// {pc, word} entries towards decode, with branch redirect flush and ack draining.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  instr_prefetch_queue_if.master       bus
);
  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        fetch_pc_reg, fetch_pc_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [3:0]         count_reg;
  logic [31:0]        instr_mem [DEPTH];
  logic [31:0]        pc_mem    [DEPTH];

  logic        pop_req;
  logic        push;
  logic        pop_en;
  logic        flush;
  logic [31:0] redirect_aligned;
  logic [4:0]  count_after_pop;
  logic [4:0]  count_after_ack;

  assign pop_req          = (count_reg != 4'd0) && bus.instr_ready;
  assign redirect_aligned = bus.redirect_pc & ~32'd3;
  assign count_after_pop  = {1'b0, count_reg} - {4'b0, pop_req};
  assign count_after_ack  = {1'b0, count_reg} + 5'd1 - {4'b0, pop_req};

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    push          = 1'b0;
    pop_en        = 1'b0;
    flush         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.redirect) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_aligned;
          state_next    = REQ;
        end else begin
          pop_en = pop_req;
          if (count_after_pop < DEPTH_C) state_next = REQ;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_aligned;
          // An ack in the same cycle retires the old request, so nothing is left to drain.
          state_next    = bus.imem_ack ? REQ : DRAIN;
        end else begin
          pop_en = pop_req;
          if (bus.imem_ack) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc_reg + 32'd4;
            state_next    = (count_after_ack < DEPTH_C) ? REQ : IDLE;
          end
        end
      end
      DRAIN: begin
        if (bus.redirect) begin
          flush         = 1'b1;
          fetch_pc_next = redirect_aligned;
          // The awaited stale ack arriving now is consumed here, otherwise keep waiting.
          state_next    = bus.imem_ack ? REQ : DRAIN;
        end else begin
          pop_en = pop_req;
          if (bus.imem_ack) state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= 4'd0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= 4'd0;
      end else begin
        if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg <= count_reg + {3'b0, push} - {3'b0, pop_en};
      end
    end
  end

  // Entry storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem[wr_ptr_reg] <= bus.imem_rdata;
      pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
    end
  end

  assign bus.imem_req    = (state_reg == REQ);
  assign bus.imem_addr   = fetch_pc_reg;
  assign bus.instr_valid = (count_reg != 4'd0);
  assign bus.instruction = instr_mem[rd_ptr_reg];
  assign bus.instr_pc    = pc_mem[rd_ptr_reg];
  assign bus.fifo_count  = count_reg;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios then random traffic, all checked
// each cycle against a queue-based behavioural model and a latency-programmable memory.
module tb_instr_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  instr_prefetch_queue_if bus ();

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: contents of the queue, next fetch address, request/drain flags.
  logic [31:0] m_pc_q[$];
  logic [31:0] m_ins_q[$];
  logic [31:0] m_fetch_pc;
  bit          m_busy;
  bit          m_drain;

  // Memory model: one pending request with a programmable latency.
  bit mem_pend;
  int mem_cnt;
  int lat;

  // Stimulus applied at the next step.
  bit          r_reset;
  bit          r_redir;
  logic [31:0] r_rpc;
  bit          r_ready;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          ack;
    logic [31:0] rdata;
    check("imem_req", {31'b0, bus.imem_req}, {31'b0, m_busy});
    if (m_busy) check("imem_addr", bus.imem_addr, m_fetch_pc);
    check("fifo_count", {28'b0, bus.fifo_count}, 32'(m_pc_q.size()));
    check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, (m_pc_q.size() != 0)});
    if (m_pc_q.size() != 0) begin
      check("instruction", bus.instruction, m_ins_q[0]);
      check("instr_pc", bus.instr_pc, m_pc_q[0]);
    end

    ack   = 1'b0;
    rdata = $urandom;
    if (r_reset) begin
      mem_pend = 1'b0;
    end else if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        ack      = 1'b1;
        mem_pend = 1'b0;
      end
    end else if (bus.imem_req) begin
      mem_pend = 1'b1;
      mem_cnt  = lat;
    end

    reset           = r_reset;
    bus.imem_ack    = ack;
    bus.imem_rdata  = rdata;
    bus.instr_ready = r_ready;
    bus.redirect    = r_redir;
    bus.redirect_pc = r_rpc;
    @(posedge clk);
    #1;

    if (r_reset) begin
      m_pc_q.delete();
      m_ins_q.delete();
      m_fetch_pc = RESET_PC;
      m_busy     = 1'b0;
      m_drain    = 1'b0;
    end else if (r_redir) begin
      m_pc_q.delete();
      m_ins_q.delete();
      m_fetch_pc = r_rpc & ~32'd3;
      if ((m_busy || m_drain) && !ack) begin
        m_busy  = 1'b0;
        m_drain = 1'b1;
      end else begin
        m_busy  = 1'b1;
        m_drain = 1'b0;
      end
    end else if (m_drain) begin
      if (ack) begin
        m_drain = 1'b0;
        m_busy  = 1'b1;
      end
    end else begin
      if (r_ready && m_pc_q.size() != 0) begin
        void'(m_pc_q.pop_front());
        void'(m_ins_q.pop_front());
      end
      if (m_busy && ack) begin
        m_pc_q.push_back(m_fetch_pc);
        m_ins_q.push_back(rdata);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (!m_busy || ack) m_busy = (m_pc_q.size() < DEPTH);
    end
  endtask

  task automatic do_reset();
    r_reset = 1'b1;
    r_redir = 1'b0;
    step();
    step();
    r_reset = 1'b0;
  endtask

  initial begin
    bit found;
    reset           = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    r_reset = 1'b1; r_redir = 1'b0; r_rpc = 32'h0; r_ready = 1'b0;
    mem_pend = 1'b0; mem_cnt = 0; lat = 1;
    m_fetch_pc = RESET_PC; m_busy = 1'b0; m_drain = 1'b0;
    @(posedge clk);
    #1;

    // Streaming with latency-1 memory and decode always ready.
    do_reset();
    r_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // Decode stalled: queue fills to DEPTH and fetching stops.
    do_reset();
    r_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("full_count", {28'b0, bus.fifo_count}, DEPTH);
    check("full_no_req", {31'b0, bus.imem_req}, 32'd0);
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    r_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // Redirect while the request to 0x8 waits on a latency-3 memory.
    do_reset();
    lat = 3;
    r_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_busy && m_fetch_pc == 32'h8 && mem_pend) found = 1'b1;
      else step();
    end
    check("wait_req8", {31'b0, found}, 32'd1);
    r_redir = 1'b1; r_rpc = 32'h0000_0102;
    step();
    r_redir = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // Redirect coincident with an ack and a pop.
    do_reset();
    lat = 2;
    r_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (m_pc_q.size() >= 2 && mem_pend && mem_cnt == 1) found = 1'b1;
      else step();
    end
    check("wait_ack_pop", {31'b0, found}, 32'd1);
    r_redir = 1'b1; r_rpc = 32'h0000_0200; r_ready = 1'b1;
    step();
    r_redir = 1'b0;
    check("redir_flush", {28'b0, bus.fifo_count}, 32'd0);
    for (int i = 0; i < 10; i++) step();

    // Second redirect while still draining a stale ack.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_busy && mem_pend && mem_cnt == 3) found = 1'b1;
      else step();
    end
    check("wait_drain", {31'b0, found}, 32'd1);
    r_redir = 1'b1; r_rpc = 32'h0000_0300;
    step();
    r_rpc = 32'h0000_0401;
    step();
    r_redir = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // Fetch address wraps from 0xFFFF_FFFC to 0.
    lat = 1;
    r_redir = 1'b1; r_rpc = 32'hFFFF_FFFC;
    step();
    r_redir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.imem_req && m_fetch_pc == 32'h0) found = 1'b1;
    end
    check("wrap_seen", {31'b0, found}, 32'd1);
    check("wrap_addr", bus.imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      lat     = int'($urandom_range(1, 3));
      r_reset = ($urandom_range(0, 99) == 0);
      r_redir = ($urandom_range(0, 19) == 0);
      r_rpc   = $urandom;
      r_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    r_reset = 1'b0;
    r_redir = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter DEPTH, 4, queue entries (power of two, 2..8).
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  byte address of requested word.
REQ-007 imem_ack  input  1  memory returns data this cycle; variable latency >= 1 cycle.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 instr_valid  output  1  head-of-queue instruction available to decode.
REQ-010 instruction  output  32  head-of-queue instruction word.
REQ-011 instr_pc  output  32  byte address of head instruction.
REQ-012 instr_ready  input  1  decode consumes head this cycle.
REQ-013 redirect  input  1  flush queue and restart fetch (branch/jump).
REQ-014 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-015 fifo_count  output  4  number of valid queue entries.

Function
REQ-016 Block SHALL sit upstream of decode/register-file stage, supplying one 32-bit word per pop.
REQ-017 At most one memory request SHALL be outstanding; outstanding = imem_req asserted and not yet acked.
REQ-018 FSM states SHALL be IDLE (no request), REQ (imem_req=1, awaiting ack), DRAIN (discard one pending ack after redirect).
REQ-019 IDLE->REQ when fifo_count after this cycle's pop < DEPTH and redirect=0; otherwise stay IDLE.
REQ-020 In REQ, imem_req and imem_addr SHALL be held stable until imem_ack=1.
REQ-021 On imem_ack in REQ (no redirect): push {imem_rdata, imem_addr} at tail, fetch_pc += 4 (mod 2^32 wrap), go REQ if space remains after push/pop, else IDLE.
REQ-022 Back-to-back: ack in cycle N with space SHALL allow new imem_req with addr+4 in cycle N+1.
REQ-023 Pushed word SHALL appear on instruction/instr_valid in cycle after ack (1-cycle latency, registered).
REQ-024 Pop occurs when instr_valid=1 and instr_ready=1; head advances next edge; instr_ready with instr_valid=0 is ignored.
REQ-025 Simultaneous push and pop SHALL leave fifo_count unchanged; pop-when-full SHALL not lose the pushed word.
REQ-026 Queue SHALL never overflow: issue decision counts the outstanding slot.
REQ-027 instr_valid SHALL equal (fifo_count != 0); instruction/instr_pc hold head entry, don't-care when empty.
REQ-028 redirect=1 SHALL have priority over all events: queue cleared (fifo_count=0 next cycle), any same-cycle pop/push ignored, fetch_pc <= redirect_pc.
REQ-029 redirect in REQ with imem_ack=0 -> DRAIN, imem_req=0; next imem_ack discarded, then REQ at redirect_pc next cycle.
REQ-030 redirect in REQ with imem_ack=1 -> returning data discarded, next state REQ at redirect_pc.
REQ-031 redirect in IDLE -> REQ at redirect_pc next cycle; redirect in DRAIN -> update fetch_pc, remain DRAIN.
REQ-032 redirect_pc low two bits SHALL be forced to 00.

Reset
REQ-033 While Reset=1: state IDLE, imem_req=0, fifo_count=0, instr_valid=0, fetch_pc=RESET_PC, pointers 0.
REQ-034 Reset SHALL override redirect and imem_ack; acks arriving during reset discarded.
REQ-035 First imem_req (addr RESET_PC) SHALL assert in the first cycle after Reset deasserts.
REQ-036 Reset mid-request SHALL abandon the request; no DRAIN required (memory reset together).

Verification
REQ-037 Reset release, ack latency 1, instr_ready=1 -> addresses 0,4,8,... one word per 2 cycles, instr_pc matches, fifo_count <= 1.
REQ-038 instr_ready=0, ack latency 1 -> exactly 4 words queued (addr 0..C), imem_req=0 with fifo_count=4; assert instr_ready one cycle -> one pop, fetch resumes at 0x10.
REQ-039 Full queue, instr_ready=1 and imem_ack same cycle -> fifo_count stays 4, order preserved, no dropped word.
REQ-040 Request outstanding to 0x8, redirect to 0x100 at latency 3 -> ack for 0x8 discarded, next imem_addr=0x100, queue empty until its ack.
REQ-041 redirect coincident with imem_ack and pop -> fifo_count=0 next cycle, next imem_addr=redirect_pc, acked word never visible.
REQ-042 fetch_pc=32'hFFFF_FFFC acked -> next imem_addr=0x0000_0000.
